// File: rtl/r_exec_pkg.sv
// r_exec_pkg: opcode encoding and shared constants for the r_exec_pipe execute unit.
package r_exec_pkg;

  localparam int ALU_OP_WIDTH = 4;

  typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_AND  = 4'b0010;
  localparam alu_op_t ALU_OR   = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_NOR  = 4'b0101;
  localparam alu_op_t ALU_SLT  = 4'b0110;
  localparam alu_op_t ALU_SLTU = 4'b0111;
  localparam alu_op_t ALU_SLL  = 4'b1000;
  localparam alu_op_t ALU_SRL  = 4'b1001;
  localparam alu_op_t ALU_SRA  = 4'b1010;

  // Defined opcodes are contiguous from ADD up to SRA; everything above is illegal.
  function automatic logic alu_op_legal(input alu_op_t op);
    return (op <= ALU_SRA);
  endfunction

endpackage

// File: rtl/r_exec_regfile.sv
// r_exec_regfile: NUM_REGS x DATA_WIDTH register file, two async read ports,
// one sync write port shared between write-back (priority) and preload.
// Register 0 is hardwired to zero; all entries clear on async active-low reset.
module r_exec_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_a,
  output logic [DATA_WIDTH-1:0] o_rd_data_a,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_b,
  output logic [DATA_WIDTH-1:0] o_rd_data_b,
  input  logic                  i_wb_en,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_ld_valid,
  input  logic                  i_ld_ready,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [DATA_WIDTH-1:0] i_ld_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // Register 0 always reads as zero regardless of storage contents.
  assign o_rd_data_a = (i_rd_addr_a == ZERO_ADDR) ? ZERO_DATA : r_regs[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == ZERO_ADDR) ? ZERO_DATA : r_regs[i_rd_addr_b];

  // Write-port arbitration: write-back wins, a preload only goes in when accepted.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = i_wb_addr;
    w_wr_data = i_wb_data;
    if (i_wb_en) begin
      w_wr_en = 1'b1;
    end else if (i_ld_valid && i_ld_ready) begin
      w_wr_en   = 1'b1;
      w_wr_addr = i_ld_addr;
      w_wr_data = i_ld_data;
    end else begin
      w_wr_en = 1'b0;
    end
  end

  // Storage update: async clear of every entry, writes to register 0 are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= ZERO_DATA;
      end
    end else if (w_wr_en && (w_wr_addr != ZERO_ADDR)) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

endmodule

// File: rtl/r_exec_pipe.sv
// r_exec_pipe: two-stage (EX -> WB) R-format execute unit with valid/ready issue,
// direct register preload and read-after-write hazard handling.
// Optional feature macro: RF_BYPASS_EN -- forward the WB result into EX instead of
// stalling issue for one cycle on a dependency.
module r_exec_pipe
  import r_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset_input,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [ADDR_WIDTH-1:0]   rs_address,
  input  logic [ADDR_WIDTH-1:0]   rt_address,
  input  logic [ADDR_WIDTH-1:0]   rd_address,
  input  logic [ALU_OP_WIDTH-1:0] alu_operation,
  input  logic                    write_enabled,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [ADDR_WIDTH-1:0]   load_address,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic                    result_valid,
  output logic [DATA_WIDTH-1:0]   result_data,
  output logic [ADDR_WIDTH-1:0]   result_address,
  output logic                    zero_flag,
  output logic                    overflow_flag,
  output logic                    illegal_flag
);

  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
  localparam int MSB         = DATA_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

  // WB stage register
  logic                  r_wb_valid;
  logic                  r_wb_we;
  logic [ADDR_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_result;
  logic                  r_wb_zero;
  logic                  r_wb_ovf;
  logic                  r_wb_ill;

  logic [DATA_WIDTH-1:0]  w_rf_rs;
  logic [DATA_WIDTH-1:0]  w_rf_rt;
  logic [DATA_WIDTH-1:0]  w_op_a;
  logic [DATA_WIDTH-1:0]  w_op_b;
  logic                   w_wb_commit;
  logic                   w_haz_rs;
  logic                   w_haz_rt;
  logic                   w_issue_fire;
  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic [DATA_WIDTH-1:0]  w_sum;
  logic [DATA_WIDTH-1:0]  w_diff;
  logic [DATA_WIDTH-1:0]  w_alu_result;
  logic                   w_alu_ovf;
  logic                   w_alu_ill;

  r_exec_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .i_clk       (clk),
    .i_rst_n     (reset_input),
    .i_rd_addr_a (rs_address),
    .o_rd_data_a (w_rf_rs),
    .i_rd_addr_b (rt_address),
    .o_rd_data_b (w_rf_rt),
    .i_wb_en     (w_wb_commit),
    .i_wb_addr   (r_wb_rd),
    .i_wb_data   (r_wb_result),
    .i_ld_valid  (load_valid),
    .i_ld_ready  (load_ready),
    .i_ld_addr   (load_address),
    .i_ld_data   (load_data)
  );

  // A WB entry that will write the regfile at the coming edge (rd=0 dropped inside).
  assign w_wb_commit = r_wb_valid & r_wb_we;
  assign load_ready  = ~w_wb_commit;

  // Read-after-write against the instruction in WB; register 0 never conflicts.
  assign w_haz_rs = w_wb_commit & (rs_address == r_wb_rd) & (rs_address != ZERO_ADDR);
  assign w_haz_rt = w_wb_commit & (rt_address == r_wb_rd) & (rt_address != ZERO_ADDR);

`ifdef RF_BYPASS_EN
  assign w_op_a      = w_haz_rs ? r_wb_result : w_rf_rs;
  assign w_op_b      = w_haz_rt ? r_wb_result : w_rf_rt;
  assign issue_ready = 1'b1;
`else
  assign w_op_a      = w_rf_rs;
  assign w_op_b      = w_rf_rt;
  assign issue_ready = ~(w_haz_rs | w_haz_rt);
`endif

  assign w_issue_fire = issue_valid & issue_ready;
  assign w_shamt      = w_op_b[SHAMT_WIDTH-1:0];
  assign w_sum        = w_op_a + w_op_b;
  assign w_diff       = w_op_a - w_op_b;
  assign w_alu_ill    = ~alu_op_legal(alu_operation);

  // ALU: result and signed-overflow for the current EX operands; illegal codes yield 0.
  always_comb begin
    w_alu_result = ZERO_DATA;
    w_alu_ovf    = 1'b0;
    case (alu_operation)
      ALU_ADD: begin
        w_alu_result = w_sum;
        w_alu_ovf    = (w_op_a[MSB] == w_op_b[MSB]) && (w_sum[MSB] != w_op_a[MSB]);
      end
      ALU_SUB: begin
        w_alu_result = w_diff;
        w_alu_ovf    = (w_op_a[MSB] != w_op_b[MSB]) && (w_diff[MSB] != w_op_a[MSB]);
      end
      ALU_AND:  w_alu_result = w_op_a & w_op_b;
      ALU_OR:   w_alu_result = w_op_a | w_op_b;
      ALU_XOR:  w_alu_result = w_op_a ^ w_op_b;
      ALU_NOR:  w_alu_result = ~(w_op_a | w_op_b);
      ALU_SLT:  w_alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLTU: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
      ALU_SLL:  w_alu_result = w_op_a << w_shamt;
      ALU_SRL:  w_alu_result = w_op_a >> w_shamt;
      ALU_SRA:  w_alu_result = $unsigned($signed(w_op_a) >>> w_shamt);
      default: begin
        w_alu_result = ZERO_DATA;
        w_alu_ovf    = 1'b0;
      end
    endcase
  end

  // WB register: holds each accepted instruction's outcome for exactly one cycle,
  // otherwise returns to an all-zero idle state.
  always_ff @(posedge clk or negedge reset_input) begin
    if (!reset_input) begin
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= ZERO_ADDR;
      r_wb_result <= ZERO_DATA;
      r_wb_zero   <= 1'b0;
      r_wb_ovf    <= 1'b0;
      r_wb_ill    <= 1'b0;
    end else if (w_issue_fire) begin
      r_wb_valid  <= 1'b1;
      r_wb_we     <= write_enabled & ~w_alu_ill;
      r_wb_rd     <= rd_address;
      r_wb_result <= w_alu_result;
      r_wb_zero   <= (w_alu_result == ZERO_DATA);
      r_wb_ovf    <= w_alu_ovf;
      r_wb_ill    <= w_alu_ill;
    end else begin
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= ZERO_ADDR;
      r_wb_result <= ZERO_DATA;
      r_wb_zero   <= 1'b0;
      r_wb_ovf    <= 1'b0;
      r_wb_ill    <= 1'b0;
    end
  end

  assign result_valid   = r_wb_valid;
  assign result_data    = r_wb_result;
  assign result_address = r_wb_rd;
  assign zero_flag      = r_wb_zero;
  assign overflow_flag  = r_wb_ovf;
  assign illegal_flag   = r_wb_ill;

endmodule

// File: tb/tb_r_exec_pipe.sv
// tb_r_exec_pipe: directed + randomized bench for r_exec_pipe (DATA_WIDTH=32,
// ADDR_WIDTH=5) against an architectural reference model.
module tb_r_exec_pipe;
  import r_exec_pkg::*;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_input = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  rs_address = 5'd0;
  logic [4:0]  rt_address = 5'd0;
  logic [4:0]  rd_address = 5'd0;
  logic [3:0]  alu_operation = 4'd0;
  logic        write_enabled = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [4:0]  load_address = 5'd0;
  logic [31:0] load_data = 32'd0;
  logic        result_valid;
  logic [31:0] result_data;
  logic [4:0]  result_address;
  logic        zero_flag, overflow_flag, illegal_flag;

  r_exec_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset_input(reset_input),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs_address(rs_address), .rt_address(rt_address), .rd_address(rd_address),
    .alu_operation(alu_operation), .write_enabled(write_enabled),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_address(load_address), .load_data(load_data),
    .result_valid(result_valid), .result_data(result_data),
    .result_address(result_address), .zero_flag(zero_flag),
    .overflow_flag(overflow_flag), .illegal_flag(illegal_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model (architectural view) ----------------
  logic [31:0] m_rf [32];
  bit          m_prev_acc;   // an instruction was accepted at the last edge
  bit          m_prev_we;    // ...and it commits (legal and write-enabled)
  logic [4:0]  m_prev_rd;
  bit          e_valid, e_zero, e_ovf, e_ill;
  logic [31:0] e_data;
  logic [4:0]  e_addr;

  bit          obs_valid, obs_zero, obs_ovf, obs_ill, obs_iready, obs_lready;
  logic [31:0] obs_data;
  logic [4:0]  obs_addr;
  bit          last_acc, last_lacc;
  int          cyc = 0, last_pulse = 0, pulse_gap = 0;

  function automatic void model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit ov, output bit il);
    int     ia, ib;
    longint s;
    int     sh;
    ia = a; ib = b; sh = int'(b[4:0]);
    r = 32'd0; ov = 1'b0; il = 1'b0;
    case (op)
      ALU_ADD:  begin s = longint'(ia) + longint'(ib); r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      ALU_SUB:  begin s = longint'(ia) - longint'(ib); r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = (ia < ib) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = ia >>> sh;
      default:  il = 1'b1;
    endcase
  endfunction

  function automatic bit exp_issue_ready();
    bit haz;
    haz = m_prev_acc && m_prev_we &&
          ((rs_address != 5'd0 && rs_address == m_prev_rd) || (rt_address != 5'd0 && rt_address == m_prev_rd));
    return BYP ? 1'b1 : !haz;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_prev_acc = 1'b0; m_prev_we = 1'b0; m_prev_rd = 5'd0;
    e_valid = 1'b0; e_data = 32'd0; e_addr = 5'd0; e_zero = 1'b0; e_ovf = 1'b0; e_ill = 1'b0;
  endfunction

  // One clock: check outputs/readies at negedge, advance the model at posedge.
  task automatic tick();
    bit ir, lr, acc, lacc, ov, il;
    logic [31:0] res;
    @(negedge clk);
    cyc++;
    check_eq("result_valid", result_valid, e_valid);
    if (e_valid) begin
      check_eq("result_data", result_data, e_data);
      check_eq("result_address", result_address, e_addr);
      check_eq("zero_flag", zero_flag, e_zero);
      check_eq("overflow_flag", overflow_flag, e_ovf);
      check_eq("illegal_flag", illegal_flag, e_ill);
    end
    ir = exp_issue_ready();
    lr = !(m_prev_acc && m_prev_we);
    check_eq("issue_ready", issue_ready, ir);
    check_eq("load_ready", load_ready, lr);
    obs_valid = result_valid; obs_data = result_data; obs_addr = result_address;
    obs_zero = zero_flag; obs_ovf = overflow_flag; obs_ill = illegal_flag;
    obs_iready = issue_ready; obs_lready = load_ready;
    if (result_valid) begin
      pulse_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    acc  = issue_valid && ir;
    lacc = load_valid && lr;
    @(posedge clk);
    res = 32'd0; ov = 1'b0; il = 1'b0;
    if (acc) model_alu(alu_operation, m_rf[rs_address], m_rf[rt_address], res, ov, il);
    if (lacc && load_address != 5'd0) m_rf[load_address] = load_data;
    if (acc) begin
      e_valid = 1'b1; e_data = res; e_addr = rd_address;
      e_zero = (res == 32'd0); e_ovf = ov; e_ill = il;
      m_prev_acc = 1'b1; m_prev_we = write_enabled && !il; m_prev_rd = rd_address;
      if (m_prev_we && rd_address != 5'd0) m_rf[rd_address] = res;
    end else begin
      e_valid = 1'b0; m_prev_acc = 1'b0; m_prev_we = 1'b0;
    end
    last_acc = acc; last_lacc = lacc;
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit we, output int stalls);
    stalls = 0;
    issue_valid = 1'b1; alu_operation = op; rs_address = rs; rt_address = rt;
    rd_address = rd; write_enabled = we;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (!obs_iready) stalls++;
      if (last_acc) break;
    end
    check_eq("issue_accepted", last_acc, 1'b1);
    issue_valid = 1'b0;
  endtask

  task automatic run(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input bit we);
    int st;
    issue(op, rs, rt, rd, we, st);
    tick();
  endtask

  task automatic expect_reg(input string tag, input logic [4:0] idx, input logic [31:0] val);
    run(ALU_OR, idx, 5'd0, 5'd0, 1'b0);
    check_eq(tag, obs_data, val);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    load_valid = 1'b1; load_address = a; load_data = d;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (last_lacc) break;
    end
    check_eq("preload_accepted", last_lacc, 1'b1);
    load_valid = 1'b0;
  endtask

  // Asserts reset a little after the current edge, holds it across an edge, releases at a negedge.
  task automatic async_reset();
    #2 reset_input = 1'b0;
    #1;
    check_eq("rst_valid", result_valid, 1'b0);
    check_eq("rst_data", result_data, 32'd0);
    check_eq("rst_addr", result_address, 5'd0);
    check_eq("rst_flags", {zero_flag, overflow_flag, illegal_flag}, 3'b000);
    check_eq("rst_issue_ready", issue_ready, 1'b1);
    check_eq("rst_load_ready", load_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset_input = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2;
    model_clear();
    @(posedge clk); #1;
    async_reset();

    // Basic ALU
    preload(5'd1, 32'd1);
    preload(5'd2, 32'd2);
    run(ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1);
    check_eq("add_data", obs_data, 32'd3);
    check_eq("add_addr", obs_addr, 5'd3);
    run(ALU_SUB, 5'd1, 5'd2, 5'd4, 1'b1);
    check_eq("sub_data", obs_data, 32'hFFFF_FFFF);
    run(ALU_SLT, 5'd4, 5'd1, 5'd5, 1'b1);
    check_eq("slt_data", obs_data, 32'd1);
    run(ALU_SLTU, 5'd4, 5'd1, 5'd5, 1'b1);
    check_eq("sltu_data", obs_data, 32'd0);
    preload(5'd7, 32'h8000_0000);
    preload(5'd8, 32'd4);
    preload(5'd10, 32'h24);
    run(ALU_SRA, 5'd7, 5'd8, 5'd9, 1'b1);
    check_eq("sra_data", obs_data, 32'hF800_0000);
    run(ALU_SRL, 5'd7, 5'd10, 5'd9, 1'b1);
    check_eq("srl_upper_ignored", obs_data, 32'h0800_0000);

    // Overflow and zero
    preload(5'd11, 32'h7FFF_FFFF);
    run(ALU_ADD, 5'd11, 5'd1, 5'd12, 1'b1);
    check_eq("ovf_data", obs_data, 32'h8000_0000);
    check_eq("ovf_flag", obs_ovf, 1'b1);
    run(ALU_SUB, 5'd1, 5'd1, 5'd13, 1'b1);
    check_eq("zero_flag_set", obs_zero, 1'b1);
    check_eq("zero_no_ovf", obs_ovf, 1'b0);

    // Register 0 and illegal opcode
    run(ALU_ADD, 5'd1, 5'd2, 5'd0, 1'b1);
    check_eq("r0_valid", obs_valid, 1'b1);
    check_eq("r0_data", obs_data, 32'd3);
    expect_reg("r0_still_zero", 5'd0, 32'd0);
    run(4'b1100, 5'd1, 5'd2, 5'd3, 1'b1);
    check_eq("illegal_flag", obs_ill, 1'b1);
    check_eq("illegal_data", obs_data, 32'd0);
    expect_reg("illegal_no_write", 5'd3, 32'd3);

    // Dependency chain
    preload(5'd3, 32'd0);
    issue(ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, s1);
    issue(ALU_ADD, 5'd3, 5'd3, 5'd4, 1'b1, s2);
    tick();
    check_eq("chain_stall_cycles", s2, BYP ? 32'd0 : 32'd1);
    check_eq("chain_pulse_gap", pulse_gap, BYP ? 32'd1 : 32'd2);
    expect_reg("chain_r4", 5'd4, 32'd6);

    // Load arbitration against a committing WB entry
    issue(ALU_ADD, 5'd1, 5'd2, 5'd6, 1'b1, s1);
    load_valid = 1'b1; load_address = 5'd6; load_data = 32'h55;
    tick();
    check_eq("load_blocked", obs_lready, 1'b0);
    tick();
    check_eq("load_taken", obs_lready, 1'b1);
    load_valid = 1'b0;
    expect_reg("load_final", 5'd6, 32'h55);

    // Reset in the write-back cycle
    preload(5'd1, 32'd5);
    issue(ALU_ADD, 5'd1, 5'd1, 5'd3, 1'b1, s1);
    async_reset();
    tick();
    check_eq("post_rst_valid", obs_valid, 1'b0);
    check_eq("post_rst_data", obs_data, 32'd0);
    check_eq("post_rst_flags", {obs_zero, obs_ovf, obs_ill}, 3'b000);
    expect_reg("post_rst_r3", 5'd3, 32'd0);
    expect_reg("post_rst_r1", 5'd1, 32'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      issue_valid   = ($urandom_range(0, 3) != 0);
      alu_operation = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      rs_address    = 5'($urandom_range(0, 7));
      rt_address    = 5'($urandom_range(0, 7));
      rd_address    = 5'($urandom_range(0, 7));
      write_enabled = ($urandom_range(0, 4) != 0);
      load_valid    = ($urandom_range(0, 4) == 0);
      load_address  = 5'($urandom_range(0, 7));
      load_data     = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom();
      tick();
    end
    issue_valid = 1'b0; load_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      expect_reg("rand_readback", 5'(i), m_rf[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
